// File: rtl/snake_engine.sv
// Snake game engine: head movement, circular body buffer, growth, collisions and game FSM.
// Define SNAKE_WALL_WRAP_EN to make the grid edges wrap instead of ending the game.
module snake_engine #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 8,
  parameter int X_BITS   = 4,
  parameter int Y_BITS   = 3,
  parameter int MAX_LEN  = 32,
  parameter int STEP_DIV = 1024,
  parameter int L_BITS   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btnUp,
  input  logic              btnDown,
  input  logic              btnLeft,
  input  logic              btnRight,
  input  logic [X_BITS-1:0] foodX,
  input  logic [Y_BITS-1:0] foodY,
  input  logic [L_BITS-1:0] rdIdx,
  output logic [X_BITS-1:0] rdX,
  output logic [Y_BITS-1:0] rdY,
  output logic              rdValid,
  output logic [X_BITS-1:0] headX,
  output logic [Y_BITS-1:0] headY,
  output logic [L_BITS-1:0] length,
  output logic              ate,
  output logic              gameOver,
  output logic              won,
  output logic [2:0]        state
);

  localparam int C_BITS = $clog2(STEP_DIV);
  localparam int P_BITS = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_SCAN   = 3'd2,
    S_COMMIT = 3'd3,
    S_OVER   = 3'd4,
    S_WON    = 3'd5
  } state_t;

  typedef enum logic [1:0] {D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3} dir_t;

  state_t              state_q, state_d;
  dir_t                dir_q, dir_d, nxt_q, nxt_d;
  logic [C_BITS-1:0]   cnt_q, cnt_d;
  logic [X_BITS-1:0]   cand_x_q, cand_x_d, head_x_q, head_x_d, rd_x_q, rd_x_d;
  logic [Y_BITS-1:0]   cand_y_q, cand_y_d, head_y_q, head_y_d, rd_y_q, rd_y_d;
  logic                grow_q, grow_d, ate_q, ate_d, over_q, over_d, won_q, won_d;
  logic                rd_vld_q, rd_vld_d;
  logic [L_BITS-1:0]   sidx_q, sidx_d, len_q, len_d;
  logic [P_BITS-1:0]   hp_q, hp_d, hp_next;
  logic [X_BITS-1:0]   body_x_q [MAX_LEN];
  logic [Y_BITS-1:0]   body_y_q [MAX_LEN];

  logic                wr_en, step_now, req_v, nx_out, wall_hit, seg_hit;
  dir_t                req_d, ref_dir;
  logic [X_BITS-1:0]   nx_x;
  logic [Y_BITS-1:0]   nx_y;
  logic [P_BITS-1:0]   scan_addr, rd_addr;
  logic [L_BITS-1:0]   scan_last, len_inc;

  // Body index 0 is the head; older segments sit at decreasing buffer addresses.
  function automatic logic [P_BITS-1:0] body_addr(input logic [P_BITS-1:0] hp,
                                                  input logic [L_BITS-1:0] idx);
    int h, i;
    h = int'(hp);
    i = int'(idx);
    if (h >= i) return P_BITS'(h - i);
    else        return P_BITS'(h + MAX_LEN - i);
  endfunction

  always_comb begin
    step_now  = (state_q == S_RUN) && (cnt_q == C_BITS'(STEP_DIV - 1));
    hp_next   = (hp_q == P_BITS'(MAX_LEN - 1)) ? '0 : hp_q + 1'b1;
    scan_addr = body_addr(hp_q, sidx_q);
    rd_addr   = body_addr(hp_q, rdIdx);
    scan_last = grow_q ? len_q - L_BITS'(1) : len_q - L_BITS'(2);
    len_inc   = len_q + 1'b1;
    seg_hit   = (body_x_q[scan_addr] == cand_x_q) && (body_y_q[scan_addr] == cand_y_q);

    req_v = btnUp | btnDown | btnLeft | btnRight;
    if (btnUp)        req_d = D_UP;
    else if (btnDown) req_d = D_DOWN;
    else if (btnLeft) req_d = D_LEFT;
    else              req_d = D_RIGHT;
    // On the step cycle the pending direction is about to become the committed one.
    ref_dir = step_now ? nxt_q : dir_q;

    nx_x   = head_x_q;
    nx_y   = head_y_q;
    nx_out = 1'b0;
    case (nxt_q)
      D_UP: begin
        if (head_y_q == '0) begin nx_out = 1'b1; nx_y = Y_BITS'(GRID_H - 1); end
        else nx_y = head_y_q - 1'b1;
      end
      D_DOWN: begin
        if (head_y_q == Y_BITS'(GRID_H - 1)) begin nx_out = 1'b1; nx_y = '0; end
        else nx_y = head_y_q + 1'b1;
      end
      D_LEFT: begin
        if (head_x_q == '0) begin nx_out = 1'b1; nx_x = X_BITS'(GRID_W - 1); end
        else nx_x = head_x_q - 1'b1;
      end
      default: begin
        if (head_x_q == X_BITS'(GRID_W - 1)) begin nx_out = 1'b1; nx_x = '0; end
        else nx_x = head_x_q + 1'b1;
      end
    endcase
`ifdef SNAKE_WALL_WRAP_EN
    wall_hit = 1'b0;
`else
    wall_hit = nx_out;
`endif

    state_d  = state_q;
    dir_d    = dir_q;
    nxt_d    = nxt_q;
    cnt_d    = cnt_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    grow_d   = grow_q;
    sidx_d   = sidx_q;
    hp_d     = hp_q;
    len_d    = len_q;
    head_x_d = head_x_q;
    head_y_d = head_y_q;
    ate_d    = 1'b0;
    over_d   = over_q;
    won_d    = won_q;
    wr_en    = 1'b0;

    if ((state_q == S_IDLE || state_q == S_RUN || state_q == S_SCAN) &&
        req_v && (req_d != dir_t'(ref_dir ^ 2'b01)))
      nxt_d = req_d;

    case (state_q)
      S_IDLE: begin
        if (req_v) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (step_now) begin
          cnt_d    = '0;
          dir_d    = nxt_q;
          cand_x_d = nx_x;
          cand_y_d = nx_y;
          grow_d   = (nx_x == foodX) && (nx_y == foodY);
          sidx_d   = '0;
          if (wall_hit) begin
            state_d = S_OVER;
            over_d  = 1'b1;
          end else begin
            state_d = S_SCAN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // The tail cell is skipped when not growing because it vacates on this move.
      S_SCAN: begin
        if (seg_hit) begin
          state_d = S_OVER;
          over_d  = 1'b1;
        end else if (sidx_q == scan_last) begin
          state_d = S_COMMIT;
        end else begin
          sidx_d = sidx_q + 1'b1;
        end
      end
      S_COMMIT: begin
        wr_en    = 1'b1;
        hp_d     = hp_next;
        head_x_d = cand_x_q;
        head_y_d = cand_y_q;
        state_d  = S_RUN;
        if (grow_q) begin
          len_d = len_inc;
          ate_d = 1'b1;
          if (len_inc == L_BITS'(MAX_LEN)) begin
            state_d = S_WON;
            won_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase

    rd_vld_d = rdIdx < len_q;
    rd_x_d   = rd_vld_d ? body_x_q[rd_addr] : '0;
    rd_y_d   = rd_vld_d ? body_y_q[rd_addr] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      dir_q    <= D_RIGHT;
      nxt_q    <= D_RIGHT;
      cnt_q    <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      grow_q   <= 1'b0;
      sidx_q   <= '0;
      hp_q     <= P_BITS'(2);
      len_q    <= L_BITS'(3);
      head_x_q <= X_BITS'(2);
      head_y_q <= '0;
      ate_q    <= 1'b0;
      over_q   <= 1'b0;
      won_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_x_q   <= '0;
      rd_y_q   <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        body_x_q[i] <= (i < 3) ? X_BITS'(i) : '0;
        body_y_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      nxt_q    <= nxt_d;
      cnt_q    <= cnt_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      grow_q   <= grow_d;
      sidx_q   <= sidx_d;
      hp_q     <= hp_d;
      len_q    <= len_d;
      head_x_q <= head_x_d;
      head_y_q <= head_y_d;
      ate_q    <= ate_d;
      over_q   <= over_d;
      won_q    <= won_d;
      rd_vld_q <= rd_vld_d;
      rd_x_q   <= rd_x_d;
      rd_y_q   <= rd_y_d;
      if (wr_en) begin
        body_x_q[hp_next] <= cand_x_q;
        body_y_q[hp_next] <= cand_y_q;
      end
    end
  end

  assign rdX      = rd_x_q;
  assign rdY      = rd_y_q;
  assign rdValid  = rd_vld_q;
  assign headX    = head_x_q;
  assign headY    = head_y_q;
  assign length   = len_q;
  assign ate      = ate_q;
  assign gameOver = over_q;
  assign won      = won_q;
  assign state    = state_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: movement, growth, walls, self-collision, win and async reset.
module tb_snake_engine;

  localparam int GRID_W   = 16;
  localparam int GRID_H   = 8;
  localparam int X_BITS   = 4;
  localparam int Y_BITS   = 3;
  localparam int MAX_LEN  = 8;
  localparam int STEP_DIV = 12;
  localparam int L_BITS   = $clog2(MAX_LEN + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
  logic [X_BITS-1:0] foodX = '0;
  logic [Y_BITS-1:0] foodY = '0;
  logic [L_BITS-1:0] rdIdx = '0;
  logic [X_BITS-1:0] rdX, headX;
  logic [Y_BITS-1:0] rdY, headY;
  logic              rdValid, ate, gameOver, won;
  logic [L_BITS-1:0] length;
  logic [2:0]        state;

  int n_checks = 0;
  int n_errors = 0;

  snake_engine #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .X_BITS(X_BITS), .Y_BITS(Y_BITS),
    .MAX_LEN(MAX_LEN), .STEP_DIV(STEP_DIV), .L_BITS(L_BITS)
  ) dut (
    .clk(clk), .reset(reset),
    .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight),
    .foodX(foodX), .foodY(foodY), .rdIdx(rdIdx),
    .rdX(rdX), .rdY(rdY), .rdValid(rdValid),
    .headX(headX), .headY(headY), .length(length),
    .ate(ate), .gameOver(gameOver), .won(won), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_step(input string tag);
    bit ok;
    wait_state(3'd3, 100, ok);
    check_eq({tag, "_commit_seen"}, 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r);
    btnUp = u; btnDown = d; btnLeft = l; btnRight = r;
    @(negedge clk);
    btnUp = 1'b0; btnDown = 1'b0; btnLeft = 1'b0; btnRight = 1'b0;
  endtask

  task automatic do_reset();
    btnUp = 1'b0; btnDown = 1'b0; btnLeft = 1'b0; btnRight = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_head(input string tag, input int x, input int y);
    check_eq({tag, "_headX"}, 32'(headX), 32'(x));
    check_eq({tag, "_headY"}, 32'(headY), 32'(y));
  endtask

  task automatic check_seg(input string tag, input int idx, input int x, input int y, input int v);
    rdIdx = L_BITS'(idx);
    @(negedge clk);
    check_eq({tag, "_rdValid"}, 32'(rdValid), 32'(v));
    check_eq({tag, "_rdX"}, 32'(rdX), 32'(x));
    check_eq({tag, "_rdY"}, 32'(rdY), 32'(y));
  endtask

  initial begin
    bit ok;
    int cnt;

    // Reset values while reset is held low
    @(negedge clk);
    check_eq("rst_state", 32'(state), 32'd0);
    check_head("rst", 2, 0);
    check_eq("rst_length", 32'(length), 32'd3);
    check_eq("rst_ate", 32'(ate), 32'd0);
    check_eq("rst_gameOver", 32'(gameOver), 32'd0);
    check_eq("rst_won", 32'(won), 32'd0);
    check_eq("rst_rdValid", 32'(rdValid), 32'd0);
    check_eq("rst_rdX", 32'(rdX), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle_hold", 32'(state), 32'd0);

    // Three plain steps right, food out of the way; step period and scan length
    foodX = 4'd9; foodY = 3'd5;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t1_run_entry", 32'(state), 32'd1);
    cnt = 0;
    while (state == 3'd1 && cnt < STEP_DIV + 5) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("t1_step_period", 32'(cnt), 32'(STEP_DIV));
    cnt = 0;
    while (state == 3'd2 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("t1_scan_cycles", 32'(cnt), 32'd2);
    check_eq("t1_commit", 32'(state), 32'd3);
    @(negedge clk);
    check_head("t1_s1", 3, 0);
    do_step("t1_s2");
    do_step("t1_s3");
    check_head("t1_s3", 5, 0);
    check_eq("t1_length", 32'(length), 32'd3);
    check_eq("t1_state", 32'(state), 32'd1);
    check_seg("t1_idx0", 0, 5, 0, 1);
    check_seg("t1_idx1", 1, 4, 0, 1);
    check_seg("t1_idx2", 2, 3, 0, 1);
    check_seg("t1_idx3", 3, 0, 0, 0);
    check_seg("t1_idx15", 15, 0, 0, 0);

    // Growth on the first step, plain move on the second
    do_reset();
    foodX = 4'd3; foodY = 3'd0;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    do_step("t2_s1");
    check_eq("t2_ate_pulse", 32'(ate), 32'd1);
    check_eq("t2_len_grow", 32'(length), 32'd4);
    check_head("t2_s1", 3, 0);
    @(negedge clk);
    check_eq("t2_ate_drop", 32'(ate), 32'd0);
    do_step("t2_s2");
    check_eq("t2_len_keep", 32'(length), 32'd4);
    check_eq("t2_ate_none", 32'(ate), 32'd0);
    check_head("t2_s2", 4, 0);
    check_seg("t2_tail", 3, 1, 0, 1);

    // Right wall
    do_reset();
    foodX = 4'd9; foodY = 3'd5;
    btnRight = 1'b1;
`ifdef SNAKE_WALL_WRAP_EN
    for (int k = 0; k < 14; k++) do_step("t3_wrap");
    check_head("t3_wrap", 0, 0);
    check_eq("t3_wrap_state", 32'(state), 32'd1);
    check_eq("t3_wrap_gameOver", 32'(gameOver), 32'd0);
    btnRight = 1'b0;
`else
    wait_state(3'd4, 400, ok);
    check_eq("t3_over_seen", 32'(ok), 32'd1);
    btnRight = 1'b0;
    check_eq("t3_gameOver", 32'(gameOver), 32'd1);
    check_head("t3_wall", 15, 0);
    btnDown = 1'b1;
    repeat (30) @(negedge clk);
    btnDown = 1'b0;
    check_eq("t3_frozen_state", 32'(state), 32'd4);
    check_head("t3_frozen", 15, 0);
    check_eq("t3_frozen_gameOver", 32'(gameOver), 32'd1);
    check_seg("t3_idx2", 2, 13, 0, 1);
`endif

    // Grow to 5 then turn Down, Left, Up into own body
    do_reset();
    foodX = 4'd3; foodY = 3'd0;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    do_step("t4_g1");
    foodX = 4'd4;
    do_step("t4_g2");
    check_eq("t4_len5", 32'(length), 32'd5);
    foodX = 4'd9; foodY = 3'd5;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    do_step("t4_down");
    check_head("t4_down", 4, 1);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    do_step("t4_left");
    check_head("t4_left", 3, 1);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    wait_state(3'd4, 100, ok);
    check_eq("t4_self_hit", 32'(ok), 32'd1);
    check_eq("t4_gameOver", 32'(gameOver), 32'd1);
    check_head("t4_hit", 3, 1);
    check_eq("t4_len", 32'(length), 32'd5);

    // Length-4 loop chasing its own tail never collides
    do_reset();
    foodX = 4'd3; foodY = 3'd0;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    do_step("t5_g");
    foodX = 4'd9; foodY = 3'd5;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    do_step("t5_d");
    press(1'b0, 1'b0, 1'b1, 1'b0);
    do_step("t5_l");
    press(1'b1, 1'b0, 1'b0, 1'b0);
    do_step("t5_u");
    check_head("t5_u", 2, 0);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    do_step("t5_r");
    press(1'b0, 1'b1, 1'b0, 1'b0);
    do_step("t5_d2");
    check_head("t5_loop", 3, 1);
    check_eq("t5_gameOver", 32'(gameOver), 32'd0);
    check_eq("t5_state", 32'(state), 32'd1);
    check_eq("t5_len", 32'(length), 32'd4);

    // Reverse request ignored; Up beats Left
    do_reset();
    foodX = 4'd9; foodY = 3'd5;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    do_step("t6_s1");
    press(1'b0, 1'b0, 1'b1, 1'b0);
    do_step("t6_rev");
    check_head("t6_rev", 4, 0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    do_step("t6_dn");
    press(1'b0, 1'b0, 1'b0, 1'b1);
    do_step("t6_rt");
    check_head("t6_rt", 5, 1);
    press(1'b1, 1'b0, 1'b1, 1'b0);
    do_step("t6_prio");
    check_head("t6_prio", 5, 0);
    check_eq("t6_gameOver", 32'(gameOver), 32'd0);

    // Grow to MAX_LEN
    do_reset();
    foodX = 4'd3; foodY = 3'd0;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    do_step("t7_g3");
    for (int k = 4; k < 8; k++) begin
      foodX = X_BITS'(k);
      do_step("t7_g");
    end
    check_eq("t7_won", 32'(won), 32'd1);
    check_eq("t7_state", 32'(state), 32'd5);
    check_eq("t7_len", 32'(length), 32'(MAX_LEN));
    check_eq("t7_ate", 32'(ate), 32'd1);
    check_head("t7", 7, 0);
    check_seg("t7_tail", 7, 0, 0, 1);

    // Async reset in the middle of a scan
    do_reset();
    foodX = 4'd9; foodY = 3'd5;
    rdIdx = '0;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    wait_state(3'd2, 100, ok);
    check_eq("t8_scan_seen", 32'(ok), 32'd1);
    check_eq("t8_rdValid_pre", 32'(rdValid), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("t8_state", 32'(state), 32'd0);
    check_head("t8", 2, 0);
    check_eq("t8_length", 32'(length), 32'd3);
    check_eq("t8_rdValid", 32'(rdValid), 32'd0);
    check_eq("t8_gameOver", 32'(gameOver), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_seg("t8_idx0", 0, 2, 0, 1);
    check_seg("t8_idx2", 2, 0, 0, 1);
    check_eq("t8_idle", 32'(state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised successor to the fixed 16x16 snake controller. It owns head movement, a circular body buffer, food-driven growth, wall and self-collision detection, and a game state machine, and exposes the body through an indexed read port for the matrix scanner. It sits between the button debouncers/food generator and the display driver. It replaces the fixed-length FIFO body and free-running move logic with one synchronous engine.

## Interface
- GRID_W, 16, columns (X range 0..GRID_W-1), 2..2^X_BITS
- GRID_H, 8, rows (Y range 0..GRID_H-1), 2..2^Y_BITS
- X_BITS, 4, X coordinate width
- Y_BITS, 3, Y coordinate width
- MAX_LEN, 32, body buffer depth; must be >= 4
- STEP_DIV, 1024, clk cycles between moves; must be >= MAX_LEN+2
- L_BITS, $clog2(MAX_LEN+1), length/index width

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low
- btnUp, btnDown, btnLeft, btnRight  input  1 each  level direction requests
- foodX  input  X_BITS  food column
- foodY  input  Y_BITS  food row
- rdIdx  input  L_BITS  body index, 0 = head
- rdX  output  X_BITS  segment X at rdIdx
- rdY  output  Y_BITS  segment Y at rdIdx
- rdValid  output  1  rdIdx < length
- headX  output  X_BITS  current head X
- headY  output  Y_BITS  current head Y
- length  output  L_BITS  current body length including head
- ate  output  1  one-cycle pulse on growth
- gameOver  output  1  collision occurred, sticky
- won  output  1  length reached MAX_LEN, sticky
- state  output  3  FSM state code

## Operation
- Reset (async, reset=0): body = (0,0),(1,0),(2,0); head (2,0); length=3; direction RIGHT; state IDLE(0); ate=gameOver=won=0; rdX/rdY/rdValid=0; step counter=0.
- States: IDLE=0, RUN=1, SCAN=2, COMMIT=3, OVER=4, WON=5.
- IDLE: any button high -> RUN; the pressed direction is latched as in RUN.
- Direction latch, active in IDLE/RUN/SCAN: priority Up>Down>Left>Right. A request opposite the last committed direction is ignored. Requests during SCAN apply to the next step.
- RUN: step counter counts clk cycles. At STEP_DIV-1: wrap counter to 0, form candidate head from the committed direction, sample foodX/foodY into grow = (candidate == food), go to SCAN.
- Candidate head: Up = Y-1, Down = Y+1, Left = X-1, Right = X+1. An out-of-grid result is handled by the wall rule (Configuration).
- SCAN: compares the candidate against one segment per cycle, index 0..n-1. n = length if grow, else length-1, because the tail vacates. Any match -> OVER. After n compares -> COMMIT.
- COMMIT (1 cycle): write candidate at new head pointer. If grow, length+1 and ate=1; otherwise the tail pointer advances too. If the new length == MAX_LEN -> WON, else RUN.
- OVER/WON: terminal. Body and outputs frozen, buttons ignored, exit only via reset.
- Food lying on the body has no effect unless the candidate equals it.
- Buffer is circular with depth MAX_LEN. Head/tail pointers wrap modulo MAX_LEN.

## Timing
- Step period in RUN: exactly STEP_DIV cycles from RUN entry to SCAN entry. The counter holds in all other states and restarts from 0 on RUN re-entry.
- Move latency: SCAN n cycles + COMMIT 1. headX/headY/length update on the clock edge leaving COMMIT.
- ate: high only during the cycle after COMMIT (registered), exactly 1 cycle.
- gameOver/won: set on the edge entering OVER/WON, held until reset.
- Read port: registered, 1-cycle latency from rdIdx to rdX/rdY/rdValid. It reflects committed body only and never shows the candidate. When rdIdx >= length: rdValid=0 and rdX=rdY=0.
- Reset mid-SCAN/COMMIT: immediate return to the reset state. No partial write is visible.

## Configuration
- SNAKE_WALL_WRAP_EN defined: edges wrap. Right from GRID_W-1 -> 0; Left from 0 -> GRID_W-1; Down from GRID_H-1 -> 0; Up from 0 -> GRID_H-1. These hold for non-power-of-two grids.
- Not defined: an out-of-grid candidate goes RUN -> OVER directly, skipping SCAN. gameOver is set on that edge and the head is unchanged.

## Test plan
- Reset, then pulse btnRight, food at (9,5): after 3 steps head=(5,0), length=3, state=1; rdIdx 0..3 reads (5,0),(4,0),(3,0),invalid.
- Food at (3,0), start Right: the first step pulses ate=1 for 1 cycle, length=4; the second step gives length=4, head=(4,0).
- With wrap off, hold Right from reset: the step that would reach X=16 sets gameOver=1, state=4, head=(15,0). With wrap on, the same step gives head=(0,0).
- Grow to length 5, then press Down, Left, Up in successive steps: the head re-enters a body cell, giving gameOver=1. A 4-cell loop with length 4 following its own tail must not set gameOver.
- Press Left while moving Right: ignored, head X keeps incrementing. Press Up and Left in the same cycle: Up wins.
- Assert reset during SCAN: all outputs return to reset values within the async assertion, and state=0.
